time_mode_ctrl: RTL and testbench

- Control sequencer for the stopwatch/countdown-timer datapath (seconds/minutes/hours registers, BCD converters, 7-segment drivers).
- Owns the single 1 Hz tick derived from CLOCK_50; replaces the divided clocks and per-register clock domains with one-cycle enables.
- Debounces the push-buttons and runs a mode FSM that emits inc/dec/load/clear strobes and the display mux select.
- The datapath then runs entirely on CLOCK_50.

---
 rtl/time_mode_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_time_mode_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_mode_ctrl.sv
// time_mode_ctrl: 1 Hz prescaler, key debouncing and stopwatch/timer mode FSM for the clock datapath.
// Define TIME_MODE_CTRL_AUTO_REPEAT_EN to auto-repeat set strobes while the set key is held in TMR_SET.

module time_mode_ctrl_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic key_n,
  output logic level,
  output logic press
);
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = (sync[1] != level) && (cnt == CNT_LAST);
  // Accepting a new level while the old one was 1 means the key just went down.
  assign press  = accept && level;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      // NOTE: two-flop synchronizer; only sync[1] is safe to use, sync[0] may be metastable.
      sync <= {sync[0], key_n};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module time_mode_ctrl #(
  parameter int unsigned TICK_DIV        = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_CYCLES   = 12500000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       mode_timer,
  input  logic       start,
  input  logic       plus,
  input  logic [1:0] field,
  input  logic       key_set_n,
  input  logic       key_clr_n,
  input  logic       tmr_zero,
  output logic       tick,
  output logic       sw_inc,
  output logic       sw_clear,
  output logic       set_inc,
  output logic       set_dec,
  output logic [1:0] set_field,
  output logic       tmr_clear,
  output logic       tmr_load,
  output logic       tmr_dec,
  output logic [1:0] disp_sel,
  output logic       alarm,
  output logic [2:0] state_dbg
);
  typedef enum logic [2:0] {
    SW_STOP   = 3'd0,
    SW_RUN    = 3'd1,
    TMR_SET   = 3'd2,
    TMR_LOAD  = 3'd3,
    TMR_RUN   = 3'd4,
    TMR_PAUSE = 3'd5,
    TMR_DONE  = 3'd6
  } state_t;

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t           state, nxt;
  logic [1:0]       mode_sync, start_sync;
  logic             mode_s, start_s;
  logic             set_level, set_press, clr_level, clr_press;
  logic             rpt_pulse, unused_levels;
  logic [PRE_W-1:0] pre_cnt;
  logic             run_entry;
  logic             n_sw_inc, n_sw_clear, n_set_inc, n_set_dec, n_tmr_clear;
  logic             n_tmr_load, n_tmr_dec, n_alarm;
  logic [1:0]       n_set_field, n_disp_sel;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      mode_sync  <= '0;
      start_sync <= '0;
    end else begin
      mode_sync  <= {mode_sync[0], mode_timer};
      start_sync <= {start_sync[0], start};
    end
  end
  assign mode_s  = mode_sync[1];
  assign start_s = start_sync[1];

  time_mode_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .key_n(key_set_n), .level(set_level), .press(set_press)
  );
  time_mode_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .key_n(key_clr_n), .level(clr_level), .press(clr_press)
  );

`ifdef TIME_MODE_CTRL_AUTO_REPEAT_EN
  localparam int unsigned RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] rpt_cnt;

  assign rpt_pulse     = (state == TMR_SET) && !set_level && (rpt_cnt == RPT_LAST);
  assign unused_levels = clr_level;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt <= '0;
    end else if ((state != TMR_SET) || set_level || set_press || rpt_pulse) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end
`else
  assign rpt_pulse     = 1'b0;
  assign unused_levels = ^{set_level, clr_level};
`endif

  // Restarting the prescaler on run entry makes the first tick a full period away.
  assign run_entry = ((nxt == SW_RUN) || (nxt == TMR_RUN)) &&
                     !((state == SW_RUN) || (state == TMR_RUN));
  assign tick      = (pre_cnt == PRE_LAST);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (run_entry || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    nxt         = state;
    n_sw_inc    = 1'b0;
    n_sw_clear  = 1'b0;
    n_set_inc   = 1'b0;
    n_set_dec   = 1'b0;
    n_set_field = set_field;
    n_tmr_clear = 1'b0;
    n_tmr_load  = 1'b0;
    n_tmr_dec   = 1'b0;
    case (state)
      SW_STOP: begin
        if (mode_s)         nxt = TMR_SET;
        else if (start_s)   nxt = SW_RUN;
        else if (clr_press) n_sw_clear = 1'b1;
      end
      SW_RUN: begin
        if (mode_s)        nxt = TMR_SET;
        else if (!start_s) nxt = SW_STOP;
        else               n_sw_inc = tick;
      end
      TMR_SET: begin
        if (!mode_s) begin
          nxt = SW_STOP;
        end else begin
          if (clr_press) begin
            n_tmr_clear = 1'b1;
          end else if ((set_press || rpt_pulse) && (field != 2'd3)) begin
            n_set_inc   = plus;
            n_set_dec   = !plus;
            n_set_field = field;
          end
          if (start_s) begin
            nxt        = TMR_LOAD;
            n_tmr_load = 1'b1;
          end
        end
      end
      TMR_LOAD: nxt = mode_s ? TMR_RUN : SW_STOP;
      TMR_RUN: begin
        if (!mode_s)       nxt = SW_STOP;
        else if (tmr_zero) nxt = TMR_DONE;
        else if (!start_s) nxt = TMR_PAUSE;
        else               n_tmr_dec = tick;
      end
      TMR_PAUSE: begin
        if (!mode_s)        nxt = SW_STOP;
        else if (clr_press) nxt = TMR_SET;
        else if (start_s)   nxt = TMR_RUN;
      end
      TMR_DONE: begin
        if (!mode_s)                                  nxt = SW_STOP;
        else if (set_press || clr_press || !start_s) nxt = TMR_SET;
      end
      default: nxt = SW_STOP;
    endcase

    n_alarm = (nxt == TMR_DONE);
    case (nxt)
      SW_STOP, SW_RUN: n_disp_sel = 2'd0;
      TMR_SET:         n_disp_sel = 2'd1;
      default:         n_disp_sel = 2'd2;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SW_STOP;
      sw_inc    <= 1'b0;
      sw_clear  <= 1'b0;
      set_inc   <= 1'b0;
      set_dec   <= 1'b0;
      set_field <= 2'd0;
      tmr_clear <= 1'b0;
      tmr_load  <= 1'b0;
      tmr_dec   <= 1'b0;
      disp_sel  <= 2'd0;
      alarm     <= 1'b0;
    end else begin
      state     <= nxt;
      sw_inc    <= n_sw_inc;
      sw_clear  <= n_sw_clear;
      set_inc   <= n_set_inc;
      set_dec   <= n_set_dec;
      set_field <= n_set_field;
      tmr_clear <= n_tmr_clear;
      tmr_load  <= n_tmr_load;
      tmr_dec   <= n_tmr_dec;
      disp_sel  <= n_disp_sel;
      alarm     <= n_alarm;
    end
  end

  assign state_dbg = state;
endmodule

// File: tb/tb_time_mode_ctrl.sv
// Directed bench for time_mode_ctrl with TICK_DIV=10, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20.

module tb_time_mode_ctrl;
  localparam logic [2:0] S_SW_STOP   = 3'd0;
  localparam logic [2:0] S_SW_RUN    = 3'd1;
  localparam logic [2:0] S_TMR_SET   = 3'd2;
  localparam logic [2:0] S_TMR_LOAD  = 3'd3;
  localparam logic [2:0] S_TMR_RUN   = 3'd4;
  localparam logic [2:0] S_TMR_PAUSE = 3'd5;
  localparam logic [2:0] S_TMR_DONE  = 3'd6;
`ifdef TIME_MODE_CTRL_AUTO_REPEAT_EN
  localparam int EXP_HOLD_STROBES = 4;
`else
  localparam int EXP_HOLD_STROBES = 1;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset_n = 1'b0, mode_timer = 1'b0, start = 1'b0, plus = 1'b1;
  logic       key_set_n = 1'b1, key_clr_n = 1'b1, tmr_zero = 1'b0;
  logic [1:0] field = 2'd0;
  logic       tick, sw_inc, sw_clear, set_inc, set_dec, tmr_clear, tmr_load, tmr_dec, alarm;
  logic [1:0] set_field, disp_sel;
  logic [2:0] state_dbg;
  logic [15:0] all_outs;

  int n_cmp = 0, n_bad = 0, cyc_n = 0;
  int n_sw_inc = 0, n_sw_clr = 0, n_set_inc = 0, n_set_dec = 0;
  int n_tmr_clr = 0, n_tmr_load = 0, n_tmr_dec = 0;
  int last_clr_cyc = 0, last_set_cyc = 0;
  logic [1:0] last_set_field = 2'd0;

  always #5 CLOCK_50 = ~CLOCK_50;

  time_mode_ctrl #(.TICK_DIV(10), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(20)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .mode_timer(mode_timer), .start(start),
    .plus(plus), .field(field), .key_set_n(key_set_n), .key_clr_n(key_clr_n),
    .tmr_zero(tmr_zero), .tick(tick), .sw_inc(sw_inc), .sw_clear(sw_clear),
    .set_inc(set_inc), .set_dec(set_dec), .set_field(set_field), .tmr_clear(tmr_clear),
    .tmr_load(tmr_load), .tmr_dec(tmr_dec), .disp_sel(disp_sel), .alarm(alarm),
    .state_dbg(state_dbg)
  );

  assign all_outs = {tick, sw_inc, sw_clear, set_inc, set_dec, set_field, tmr_clear,
                     tmr_load, tmr_dec, disp_sel, alarm, state_dbg};

  always @(posedge CLOCK_50) cyc_n++;

  // Strobe counters, sampled mid-cycle.
  always @(negedge CLOCK_50) begin
    if (reset_n) begin
      if (sw_inc)    n_sw_inc++;
      if (sw_clear)  begin n_sw_clr++; last_clr_cyc = cyc_n; end
      if (set_inc)   n_set_inc++;
      if (set_dec)   n_set_dec++;
      if (set_inc || set_dec) begin last_set_cyc = cyc_n; last_set_field = set_field; end
      if (tmr_clear) n_tmr_clr++;
      if (tmr_load)  n_tmr_load++;
      if (tmr_dec)   n_tmr_dec++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string tag);
    for (int i = 0; i < max && state_dbg != s; i++) cyc();
    check(tag, state_dbg, s);
  endtask

  task automatic press(input bit set_k, input bit clr_k, input int hold, output int fall);
    if (set_k) key_set_n = 1'b0;
    if (clr_k) key_clr_n = 1'b0;
    fall = cyc_n;
    cyc(hold);
    key_set_n = 1'b1;
    key_clr_n = 1'b1;
    cyc(12);
  endtask

  initial begin
    int fall, b, b2;
    logic [63:0] pat, pat2;
    bit found;

    // Reset
    cyc(3);
    check("reset_outputs", all_outs, 16'h0);
    reset_n = 1'b1;
    cyc(8);
    check("idle_state", state_dbg, S_SW_STOP);

    // Stopwatch: sw_inc on cycles 10/20/30 after SW_RUN entry, tick one cycle earlier
    start = 1'b1;
    wait_state(S_SW_RUN, 8, "sw_run_entry");
    pat = '0; pat2 = '0;
    for (int k = 1; k <= 35; k++) begin
      cyc();
      if (sw_inc) pat[k] = 1'b1;
      if (tick)   pat2[k] = 1'b1;
    end
    check("sw_inc_cycles", pat, (64'd1 << 10) | (64'd1 << 20) | (64'd1 << 30));
    check("tick_cycles", pat2, (64'd1 << 9) | (64'd1 << 19) | (64'd1 << 29));
    start = 1'b0;
    b = n_sw_inc;
    cyc(40);
    check("sw_inc_after_stop", n_sw_inc - b, 0);
    check("sw_stop_state", state_dbg, S_SW_STOP);
    b = n_sw_clr;
    press(1'b0, 1'b1, 12, fall);
    check("sw_clear_count", n_sw_clr - b, 1);
    check("sw_clear_latency", last_clr_cyc - fall, 6);

    // Timer setpoint editing
    mode_timer = 1'b1;
    wait_state(S_TMR_SET, 8, "tmr_set_entry");
    check("disp_set", disp_sel, 2'd1);
    field = 2'd0; plus = 1'b1;
    b = n_set_inc;
    for (int i = 0; i < 10; i++) begin
      key_set_n = i[0];
      cyc(2);
    end
    key_set_n = 1'b0;
    fall = cyc_n;
    cyc(12);
    key_set_n = 1'b1;
    cyc(12);
    check("bounce_set_inc_count", n_set_inc - b, 1);
    check("bounce_latency", last_set_cyc - fall, 6);
    check("bounce_field", last_set_field, 2'd0);

    field = 2'd1; plus = 1'b0;
    b = n_set_inc; b2 = n_set_dec;
    press(1'b1, 1'b0, 12, fall);
    check("dec_count", n_set_dec - b2, 1);
    check("dec_no_inc", n_set_inc - b, 0);
    check("dec_field", last_set_field, 2'd1);

    field = 2'd3; plus = 1'b1;
    b = n_set_inc + n_set_dec;
    press(1'b1, 1'b0, 12, fall);
    check("field3_no_strobe", n_set_inc + n_set_dec - b, 0);

    field = 2'd0;
    b = n_set_inc + n_set_dec; b2 = n_tmr_clr;
    press(1'b1, 1'b1, 12, fall);
    check("set_clr_clear", n_tmr_clr - b2, 1);
    check("set_clr_no_set", n_set_inc + n_set_dec - b, 0);

    // Load, run, expire on a tick cycle
    start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (tmr_load) found = 1'b1;
    end
    check("tmr_load_seen", found, 1'b1);
    check("load_state", state_dbg, S_TMR_LOAD);
    check("load_disp", disp_sel, 2'd2);
    cyc();
    check("load_one_cycle", tmr_load, 1'b0);
    check("run_state", state_dbg, S_TMR_RUN);
    pat = '0;
    for (int k = 1; k <= 29; k++) begin
      cyc();
      if (tmr_dec) pat[k] = 1'b1;
    end
    check("tmr_dec_cycles", pat, (64'd1 << 10) | (64'd1 << 20));
    check("tick_at_zero", tick, 1'b1);
    tmr_zero = 1'b1;
    cyc();
    check("done_state", state_dbg, S_TMR_DONE);
    check("done_alarm", alarm, 1'b1);
    check("done_no_dec", tmr_dec, 1'b0);
    check("done_disp", disp_sel, 2'd2);
    cyc(3);
    check("alarm_held", alarm, 1'b1);
    tmr_zero = 1'b0;
    start = 1'b0;
    wait_state(S_TMR_SET, 8, "done_to_set");
    check("set_alarm_cleared", alarm, 1'b0);
    check("set_disp_again", disp_sel, 2'd1);

    // Pause and resume
    b = n_tmr_load;
    start = 1'b1;
    wait_state(S_TMR_RUN, 10, "rerun_entry");
    cyc(5);
    start = 1'b0;
    wait_state(S_TMR_PAUSE, 8, "pause_entry");
    b2 = n_tmr_dec;
    cyc(25);
    check("pause_no_dec", n_tmr_dec - b2, 0);
    start = 1'b1;
    wait_state(S_TMR_RUN, 8, "resume_entry");
    check("resume_no_reload", n_tmr_load - b, 1);
    cyc(10);
    check("resume_first_dec", tmr_dec, 1'b1);
    mode_timer = 1'b0;
    wait_state(S_SW_STOP, 8, "abort_to_sw");
    check("abort_disp", disp_sel, 2'd0);

    // Held set key
    start = 1'b0;
    mode_timer = 1'b1;
    wait_state(S_TMR_SET, 8, "hold_set_entry");
    field = 2'd2; plus = 1'b1;
    b = n_set_inc;
    press(1'b1, 1'b0, 70, fall);
    check("hold_strobe_count", n_set_inc - b, EXP_HOLD_STROBES);
    check("hold_field", last_set_field, 2'd2);

    // Reset in the middle of a hold
    key_set_n = 1'b0;
    cyc(30);
    reset_n = 1'b0;
    #1;
    check("reset_mid_hold", all_outs, 16'h0);
    key_set_n = 1'b1;
    mode_timer = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    b = n_set_inc + n_set_dec;
    cyc(15);
    check("no_strobe_after_reset", n_set_inc + n_set_dec - b, 0);
    check("post_reset_state", state_dbg, S_SW_STOP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
